// File: rtl/waterfall_pkg.sv
// Shared widths, FSM state encodings and bit-scan helpers for the
// waterfall LED bus decoder/encoder pair.
package waterfall_pkg;

  localparam int unsigned LED_W = 16;
  localparam int unsigned IDX_W = 4;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  function automatic logic [IDX_W:0] f_popcount(input logic [LED_W-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < LED_W; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] f_hi_idx(input logic [LED_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_encoder_16_4_stable_filter.sv
// stable_filter: 2-flop synchroniser plus hold-time filter; strobes o_accept
// when a new bus value has been steady for STABLE_CYC+1 synchronised samples.
module stable_filter #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_s,
  output logic             o_accept
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_s_q;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_same;

  assign w_same   = (r_sync2 == r_s_q);
  // A value equal to the last accepted one never re-triggers.
  assign o_accept = w_same && (r_cnt == CNT_W'(STABLE_CYC - 1)) && (r_sync2 != r_acc);
  assign o_s      = r_sync2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_s_q   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
      r_s_q   <= r_sync2;
      if (!w_same) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_W'(STABLE_CYC)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (o_accept) r_acc <= r_sync2;
    end
  end

endmodule

// File: rtl/onehot_encoder_16_4.sv
// 16-bit one-hot bus to 4-bit position code with validity/fault classification.
// Optional +/-1 step detection is built when DIR_DETECT_EN is defined.
module onehot_encoder_16_4
  import waterfall_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk100MHz,
  input  logic             reset,
  input  logic [LED_W-1:0] d_in,
  output logic [IDX_W-1:0] code,
  output logic             valid,
  output logic             err,
  output logic             change,
  output logic             dir_up,
  output logic             dir_down
);

  logic [LED_W-1:0] w_s;
  logic             w_accept;
  logic [IDX_W:0]   w_pop;
  logic [IDX_W-1:0] w_hi;
  logic [1:0]       w_new_state;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_code;
  logic             r_valid;
  logic             r_err;
  logic             r_change;

  stable_filter #(
    .WIDTH      (LED_W),
    .STABLE_CYC (STABLE_CYC),
    .CNT_W      (CNT_W)
  ) u_filter (
    .i_clk    (clk100MHz),
    .i_rst    (reset),
    .i_d      (d_in),
    .o_s      (w_s),
    .o_accept (w_accept)
  );

  assign w_pop = f_popcount(w_s);
  assign w_hi  = f_hi_idx(w_s);

  always_comb begin
    w_new_state = ST_FAULT;
    if (w_pop == '0) begin
      w_new_state = ST_EMPTY;
    end else if (w_pop == {{IDX_W{1'b0}}, 1'b1}) begin
      w_new_state = ST_LOCKED;
    end
  end

  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      r_state  <= ST_EMPTY;
      r_code   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_change <= w_accept;
      if (w_accept) begin
        r_state <= w_new_state;
        r_valid <= (w_new_state == ST_LOCKED);
        r_err   <= (w_new_state == ST_FAULT);
        // An empty bus keeps the last reported position.
        if (w_new_state != ST_EMPTY) r_code <= w_hi;
      end
    end
  end

`ifdef DIR_DETECT_EN
  logic w_step;
  logic r_dir_up;
  logic r_dir_down;

  // While LOCKED, r_code already holds the previous locked position.
  assign w_step = w_accept && (w_new_state == ST_LOCKED) && (r_state == ST_LOCKED);

  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      r_dir_up   <= 1'b0;
      r_dir_down <= 1'b0;
    end else begin
      r_dir_up   <= w_step && (w_hi == IDX_W'(r_code + IDX_W'(1)));
      r_dir_down <= w_step && (w_hi == IDX_W'(r_code - IDX_W'(1)));
    end
  end

  assign dir_up   = r_dir_up;
  assign dir_down = r_dir_down;
`else
  assign dir_up   = 1'b0;
  assign dir_down = 1'b0;
`endif

  assign code   = r_code;
  assign valid  = r_valid;
  assign err    = r_err;
  assign change = r_change;

endmodule

// File: tb/tb_onehot_encoder_16_4.sv
// Table-driven bench for onehot_encoder_16_4 with an expected-event scoreboard;
// direction checks follow DIR_DETECT_EN.
module tb_onehot_encoder_16_4;

  localparam int SC = 4;
`ifdef DIR_DETECT_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif
  localparam int LONG = SC + 6;

  typedef struct {
    logic [15:0] d;
    int          hold;
    bit          chg;
    logic [3:0]  code;
    bit          valid;
    bit          err;
    bit          up;
    bit          dn;
  } vec_t;

  typedef struct {
    logic [3:0] code;
    bit         valid;
    bit         err;
    bit         up;
    bit         dn;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] d_in;
  logic [3:0]  code;
  logic        valid;
  logic        err;
  logic        change;
  logic        dir_up;
  logic        dir_down;

  int   n_vec;
  int   n_bad;
  exp_t sb[$];
  vec_t vecs[$];
  logic [3:0] last_code;
  logic       last_valid;
  logic       last_err;

  onehot_encoder_16_4 #(
    .STABLE_CYC (SC),
    .CNT_W      (8)
  ) dut (
    .clk100MHz (clk),
    .reset     (reset),
    .d_in      (d_in),
    .code      (code),
    .valid     (valid),
    .err       (err),
    .change    (change),
    .dir_up    (dir_up),
    .dir_down  (dir_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run 'hold' cycles; an expected event must appear exactly SC+3 edges in.
  task automatic run(input int hold);
    exp_t e;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() != 0 && i == SC + 3) check("change_on_time", 32'(change), 32'd1);
      if (change) begin
        if (sb.size() == 0) begin
          check("spurious_change", 32'(change), 32'd0);
        end else begin
          e = sb.pop_front();
          check("code", 32'(code), 32'(e.code));
          check("valid", 32'(valid), 32'(e.valid));
          check("err", 32'(err), 32'(e.err));
          check("dir_up", 32'(dir_up), 32'(e.up));
          check("dir_down", 32'(dir_down), 32'(e.dn));
          last_code  = e.code;
          last_valid = e.valid;
          last_err   = e.err;
        end
      end else begin
        check("steady", 32'({code, valid, err, dir_up, dir_down}),
              32'({last_code, last_valid, last_err, 2'b00}));
      end
    end
    sb.delete();
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    last_code  = '0;
    last_valid = 1'b0;
    last_err   = 1'b0;
    reset      = 1'b1;
    d_in       = 16'hFFFF;

    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_outputs", 32'({code, valid, err, change, dir_up, dir_down}), 32'd0);
    end
    d_in = 16'h0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(LONG);

    //                d         hold  chg code   v  e  up      dn
    vecs.push_back('{16'h0001, LONG, 1, 4'd0,  1, 0, 0,      0});
    vecs.push_back('{16'h0010, 2,    0, 4'd0,  0, 0, 0,      0});
    vecs.push_back('{16'h0001, LONG, 0, 4'd0,  0, 0, 0,      0});
    vecs.push_back('{16'h0300, LONG, 1, 4'd9,  0, 1, 0,      0});
    vecs.push_back('{16'h0000, LONG, 1, 4'd9,  0, 0, 0,      0});
    vecs.push_back('{16'h8000, LONG, 1, 4'd15, 1, 0, 0,      0});
    vecs.push_back('{16'h0001, LONG, 1, 4'd0,  1, 0, DIR_EN, 0});
    vecs.push_back('{16'h8000, LONG, 1, 4'd15, 1, 0, 0,      DIR_EN});
    vecs.push_back('{16'h0100, LONG, 1, 4'd8,  1, 0, 0,      0});
    vecs.push_back('{16'h0200, LONG, 1, 4'd9,  1, 0, DIR_EN, 0});
    vecs.push_back('{16'h0100, LONG, 1, 4'd8,  1, 0, 0,      DIR_EN});
    vecs.push_back('{16'h0004, SC,   0, 4'd0,  0, 0, 0,      0});
    vecs.push_back('{16'h0100, LONG, 0, 4'd0,  0, 0, 0,      0});
    vecs.push_back('{16'h0400, LONG, 1, 4'd10, 1, 0, 0,      0});
    vecs.push_back('{16'hFFFF, LONG, 1, 4'd15, 0, 1, 0,      0});
    vecs.push_back('{16'h0001, LONG, 1, 4'd0,  1, 0, 0,      0});
    vecs.push_back('{16'h0002, LONG, 1, 4'd1,  1, 0, DIR_EN, 0});

    foreach (vecs[k]) begin
      d_in = vecs[k].d;
      if (vecs[k].chg) sb.push_back('{vecs[k].code, vecs[k].valid, vecs[k].err,
                                      vecs[k].up, vecs[k].dn});
      run(vecs[k].hold);
    end

    // Reset two cycles into a hold; acceptance must restart from scratch.
    d_in = 16'h0004;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    check("midreset_clear", 32'({code, valid, err, change, dir_up, dir_down}), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("midreset_held", 32'({code, valid, err, change, dir_up, dir_down}), 32'd0);
    end
    reset      = 1'b0;
    last_code  = '0;
    last_valid = 1'b0;
    last_err   = 1'b0;
    sb.push_back('{4'd2, 1'b1, 1'b0, 1'b0, 1'b0});
    run(LONG);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
